regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a built-in write-pending scoreboard. It serves as the architectural register bank for the dual-issue pipeline. It offers NUM_READ combinational read ports and two synchronous write ports with defined same-address priority. A per-register busy bit is set when a producer instruction issues and cleared when its result is written back, so decode can detect RAW hazards without external tracking. Register 0 is hardwired to zero and is never busy.

## Interface
- WIDTH, 32: data width of each register.
- DEPTH, 32: number of registers, including x0; must be a power of two, at least 2.
- NUM_READ, 2: number of read ports, from 1 to 8.
- AW, $clog2(DEPTH): address width (localparam).
- clk  in  1  clock; all state updates occur on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr_flat  in  NUM_READ*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data_flat  out  NUM_READ*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
- rd_busy  out  NUM_READ  bit i is high when the register addressed by port i has a pending producer.
- wr_en0, wr_en1  in  1 each  write enables for write ports 0 and 1.
- wr_addr0, wr_addr1  in  AW each  write addresses.
- wr_data0, wr_data1  in  WIDTH each  write data.
- rsv_en  in  1  reserve request: marks rsv_addr as busy.
- rsv_addr  in  AW  register to reserve.
- busy_count  out  AW+1  number of registers currently marked busy.

## Operation
- Storage covers registers 1..DEPTH-1. A read of address 0 always returns 0 and always reports busy 0.
- Writes:
  - A write with address 0 is ignored.
  - When wr_en0 and wr_en1 are both high with equal nonzero addresses, port 1 data is stored and port 0 is dropped.
- Scoreboard: there is one busy bit per register; bit 0 is constantly 0. At the clock edge, for each register r != 0:
  - The bit is set if rsv_en is high and rsv_addr equals r. Reserve has priority over clear.
  - Otherwise the bit is cleared if any enabled write port targets r.
  - Otherwise the bit holds.
- A write to a register that is not busy is legal. It updates the data and leaves the busy bit at 0.
- A reserve of a register that is already busy is legal. The bit stays 1, and busy_count does not change.
- busy_count is a registered population count of the busy bits, updated on every edge together with them. It never exceeds DEPTH-1.
- Reads are combinational on every port, independently. All ports may address the same register.

## Timing
- On reset assertion, all registers, all busy bits and busy_count go to 0 immediately, without waiting for clk. As a result rd_data reads 0 and rd_busy reads 0 on every port.
- Deasserting reset mid-operation discards any in-flight reservations. The first edge after deassertion processes inputs normally.
- Write latency: data is visible in the storage array from the edge that samples wr_en.
- Reserve latency: rd_busy reflects a reservation starting the cycle after the edge that samples rsv_en. Reserve and read in the same cycle reports the old busy state.
- There are no handshakes. Every request presented at an edge is accepted.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- When defined, same-cycle forwarding is enabled:
  - rd_data for a nonzero address returns wr_data1 if wr_en1 and the addresses match.
  - Otherwise it returns wr_data0 if wr_en0 and the addresses match.
  - Otherwise it returns the stored value.
  - rd_busy is forced to 0 when any enabled write targets that address in the same cycle.
- When undefined:
  - Reads return only the stored value. A same-cycle write becomes visible one cycle later.
  - rd_busy equals the stored busy bit.

## Test plan
- Reset: write 0xDEADBEEF to x5 and reserve x6, then pulse reset between edges. Required response: rd_data for x5 is 0, rd_busy is 0 and busy_count is 0 immediately, before the next edge.
- Dual-write conflict: wr_en0 = wr_en1 = 1, both addressed to x7, with data 0x11 and 0x22. Required response: the next cycle reads 0x22. A write of 0x55 to x0 is followed by a read of x0 returning 0.
- Scoreboard lifecycle: reserve x3, then x9, then reserve x3 again. Required response: busy_count sequence 1, 2, 2. Then write x3 = 0xA5, and the following cycle shows rd_busy for x3 as 0, x9 still 1, and busy_count 1.
- Reserve/clear collision: rsv_addr = x4 and wr_addr0 = x4 in the same cycle, with x4 already busy. Required response: x4 stays busy, busy_count is unchanged, and the data equals the written value.
- Bypass, macro defined: x2 holds 0x10, write 0x99 to x2 and read it on all NUM_READ ports in the same cycle. Required response: every port returns 0x99 with rd_busy 0.
- Bypass, macro undefined: the same stimulus returns 0x10 on every port in that cycle and 0x99 on the next.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NUM_READ = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    rd_addr_flat,
  output logic [NUM_READ*WIDTH-1:0] rd_data_flat,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic                      wr_en0,
  input  logic                      wr_en1,
  input  logic [AW-1:0]             wr_addr0,
  input  logic [AW-1:0]             wr_addr1,
  input  logic [WIDTH-1:0]          wr_data0,
  input  logic [WIDTH-1:0]          wr_data1,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic [AW:0]               busy_count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [AW:0]      cnt_nxt;
  // next busy bits: reserve wins over write-back clear, x0 never busy
  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < DEPTH; r++)
      busy_nxt[r] = (rsv_en && rsv_addr == AW'(r)) ? 1'b1 :
                    ((wr_en0 && wr_addr0 == AW'(r)) || (wr_en1 && wr_addr1 == AW'(r))) ? 1'b0 : busy[r];
  end
  // population count of the next busy vector
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end
  // storage and scoreboard; port 1 is written last so it wins an address tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_en0 && wr_addr0 != '0) mem[wr_addr0] <= wr_data0;
      if (wr_en1 && wr_addr1 != '0) mem[wr_addr1] <= wr_data1;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] q;
    logic             h0, h1;
    assign a  = rd_addr_flat[i*AW +: AW];
    assign q  = (a == '0) ? '0 : mem[a];
    assign h0 = wr_en0 && wr_addr0 == a && a != '0;
    assign h1 = wr_en1 && wr_addr1 == a && a != '0;
`ifdef REGFILE_MP_BYPASS_EN
    assign rd_data_flat[i*WIDTH +: WIDTH] = h1 ? wr_data1 : h0 ? wr_data0 : q;
    assign rd_busy[i] = busy[a] && !(h0 || h1);
`else
    assign rd_data_flat[i*WIDTH +: WIDTH] = q;
    assign rd_busy[i] = busy[a] && !(1'b0 && (h0 || h1));
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp (default parameters).
module tb_regfile_mp;
  localparam int W = 32, AW = 5, NR = 2;
  logic clk = 0, reset = 1;
  logic [NR*AW-1:0] rd_addr_flat;
  logic [NR*W-1:0]  rd_data_flat;
  logic [NR-1:0]    rd_busy;
  logic wr_en0, wr_en1, rsv_en;
  logic [AW-1:0] wr_addr0, wr_addr1, rsv_addr;
  logic [W-1:0]  wr_data0, wr_data1;
  logic [AW:0]   busy_count;
  int total = 0, bad = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr_flat(rd_addr_flat), .rd_data_flat(rd_data_flat),
    .rd_busy(rd_busy), .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr0(wr_addr0),
    .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we0; logic [AW-1:0] wa0; logic [W-1:0] wd0;
    logic we1; logic [AW-1:0] wa1; logic [W-1:0] wd1;
    logic rv;  logic [AW-1:0] ra;
    logic [AW-1:0] r0, r1;
    logic [W-1:0] e0, e1; logic eb0, eb1; logic [AW:0] ec;
  } vec_t;
  vec_t v [12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en0 = 0; wr_en1 = 0; rsv_en = 0;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic eb0, input logic eb1, input logic [AW:0] ec);
    chk({tag, ".d0"}, rd_data_flat[0 +: W], e0);
    chk({tag, ".d1"}, rd_data_flat[W +: W], e1);
    chk({tag, ".b0"}, W'(rd_busy[0]), W'(eb0));
    chk({tag, ".b1"}, W'(rd_busy[1]), W'(eb1));
    chk({tag, ".cnt"}, W'(busy_count), W'(ec));
  endtask

  initial begin
    //        we0 wa0 wd0          we1 wa1 wd1    rv ra  r0 r1  e0           e1     eb0 eb1 ec
    v[0]  = '{1, 7, 32'h11,       1, 7, 32'h22,  0, 0,  7, 0, 32'h22,      32'h0,  0, 0, 0};
    v[1]  = '{1, 0, 32'h55,       0, 0, 32'h0,   0, 0,  0, 7, 32'h0,       32'h22, 0, 0, 0};
    v[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 3,  3, 9, 32'h0,       32'h0,  1, 0, 1};
    v[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 9,  3, 9, 32'h0,       32'h0,  1, 1, 2};
    v[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 3,  3, 9, 32'h0,       32'h0,  1, 1, 2};
    v[5]  = '{1, 3, 32'hA5,       0, 0, 32'h0,   0, 0,  3, 9, 32'hA5,      32'h0,  0, 1, 1};
    v[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 4,  4, 9, 32'h0,       32'h0,  1, 1, 2};
    v[7]  = '{1, 4, 32'h44,       0, 0, 32'h0,   1, 4,  4, 9, 32'h44,      32'h0,  1, 1, 2};
    v[8]  = '{1, 4, 32'h40,       1, 9, 32'h99,  0, 0,  4, 9, 32'h40,      32'h99, 0, 0, 0};
    v[9]  = '{0, 0, 32'h0,        1, 5, 32'h5,   0, 0,  5, 7, 32'h5,       32'h22, 0, 0, 0};
    v[10] = '{1, 2, 32'h10,       0, 0, 32'h0,   0, 0,  2, 2, 32'h10,      32'h10, 0, 0, 0};
    v[11] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 2,  2, 3, 32'h10,      32'hA5, 1, 0, 1};

    idle(); wr_addr0 = 0; wr_addr1 = 0; wr_data0 = 0; wr_data1 = 0; rsv_addr = 0;
    rd_addr_flat = {AW'(6), AW'(5)};
    #12;
    check_all("reset_init", 0, 0, 0, 0, 0);
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      wr_en0 = v[i].we0; wr_addr0 = v[i].wa0; wr_data0 = v[i].wd0;
      wr_en1 = v[i].we1; wr_addr1 = v[i].wa1; wr_data1 = v[i].wd1;
      rsv_en = v[i].rv;  rsv_addr = v[i].ra;
      rd_addr_flat = {v[i].r1, v[i].r0};
      @(posedge clk); #1;
      idle(); #1;
      check_all($sformatf("vec%0d", i), v[i].e0, v[i].e1, v[i].eb0, v[i].eb1, v[i].ec);
    end

    // same-cycle write to busy x2 (holding 0x10) read on every port
    wr_en0 = 1; wr_addr0 = 2; wr_data0 = 32'h99; rd_addr_flat = {AW'(2), AW'(2)};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check_all("bypass_same", 32'h99, 32'h99, 0, 0, 1);
`else
    check_all("bypass_same", 32'h10, 32'h10, 1, 1, 1);
`endif
    @(posedge clk); #1; idle(); #1;
    check_all("bypass_next", 32'h99, 32'h99, 0, 0, 0);

    // async reset between edges
    wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
    rd_addr_flat = {AW'(6), AW'(5)};
    @(posedge clk); #1; idle(); #1;
    check_all("pre_reset", 32'hDEADBEEF, 0, 0, 1, 1);
    reset = 1; #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    #1 reset = 0;

    // normal operation right after deassertion
    wr_en1 = 1; wr_addr1 = 1; wr_data1 = 32'h1234; rsv_en = 1; rsv_addr = 8;
    rd_addr_flat = {AW'(8), AW'(1)};
    @(posedge clk); #1; idle(); #1;
    check_all("post_reset", 32'h1234, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
